pwm_capture: RTL and testbench

- Measures the PWM waveform produced by the team's PWM generator and sits directly downstream of it.
- Samples the single-bit PWM output in the same clock domain and reports, once per period, two values: the high time and the period, both in clock cycles.
- Results go to the consumer through a valid/ready handshake.
- Sticky status flags report a lost result (overrun) and a stuck line (no edge before the counter saturates).

---
 rtl/pwm_pkg.sv | 12 +
 rtl/edge_detect.sv | 24 ++
 rtl/pwm_capture.sv | 154 +++++++++++++++
 tb/tb_pwm_capture.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Types and constants shared by the PWM generator and the PWM capture block.
package pwm_pkg;

  localparam int PWM_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cap_state_t;

endpackage

// File: rtl/edge_detect.sv
// Registers the PWM line once and flags rising and falling edges against that copy.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm,
  output logic rise,
  output logic fall
);

  logic pwm_q;

  // Resetting to 0 makes a line already high at reset release read as a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= pwm;
    end
  end

  assign rise = pwm & ~pwm_q;
  assign fall = ~pwm & pwm_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of a synchronous PWM line, one result per period,
// delivered over valid/ready with sticky overrun and stuck-line flags.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int W = PWM_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         pwm,
  input  logic         out_ready,
  input  logic         clr,
  output logic         out_valid,
  output logic [W-1:0] period_o,
  output logic [W-1:0] high_o,
  output logic         ovr,
  output logic         stuck
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic rise;
  logic fall;

  cap_state_t   state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] hi_lat_q, hi_lat_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] period_q, period_d;
  logic [W-1:0] high_q, high_d;
  logic         ovr_q, ovr_d;
  logic         stuck_q, stuck_d;
  logic         emit;
  logic         stuck_set;

  edge_detect u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .pwm  (pwm),
    .rise (rise),
    .fall (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_lat_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_lat_q <= hi_lat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_lat_d  = hi_lat_q;
    emit      = 1'b0;
    stuck_set = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = HIGH;
            cnt_d   = CNT_ONE;
          end
        end
        HIGH: begin
          // The fall cycle is the first low cycle, so it still counts toward the period.
          if (fall) begin
            hi_lat_d = cnt_q;
            state_d  = LOW;
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else if (cnt_q == CNT_MAX) begin
            stuck_set = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        LOW: begin
          if (rise) begin
            emit    = 1'b1;
            state_d = HIGH;
            cnt_d   = CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            stuck_set = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Result register and sticky flags; a set in the same cycle as clr wins.
  always_comb begin
    out_valid_d = out_valid_q;
    period_d    = period_q;
    high_d      = high_q;
    ovr_d       = ovr_q & ~clr;
    stuck_d     = (stuck_q & ~clr) | stuck_set;
    if (emit) begin
      if (!out_valid_q || out_ready) begin
        period_d    = cnt_q;
        high_d      = hi_lat_q;
        out_valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      period_q    <= '0;
      high_q      <= '0;
      ovr_q       <= 1'b0;
      stuck_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      period_q    <= period_d;
      high_q      <= high_d;
      ovr_q       <= ovr_d;
      stuck_q     <= stuck_d;
    end
  end

  assign out_valid = out_valid_q;
  assign period_o  = period_q;
  assign high_o    = high_q;
  assign ovr       = ovr_q;
  assign stuck     = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture at W=8: steady, overrun, stuck, duty change,
// edge-case periods, and reset / enable drop mid-measurement.
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0;
  logic         pwm = 1'b0;
  logic         out_ready = 1'b0;
  logic         clr = 1'b0;
  logic         out_valid;
  logic [W-1:0] period_o;
  logic [W-1:0] high_o;
  logic         ovr;
  logic         stuck;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pwm_capture #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .pwm      (pwm),
    .out_ready(out_ready),
    .clr      (clr),
    .out_valid(out_valid),
    .period_o (period_o),
    .high_o   (high_o),
    .ovr      (ovr),
    .stuck    (stuck)
  );

  // Drive the line, let one rising edge sample it, observe 1 ns later.
  task automatic cyc(input logic p);
    pwm = p;
    @(posedge clk);
    #1;
  endtask

  function automatic logic wave(input int i, input int p, input int h);
    return (i % p) < h;
  endfunction

  task automatic go_idle();
    en = 1'b0;
    out_ready = 1'b1;
    clr = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    clr = 1'b0;
    en = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (period_o !== 8'd0) begin n_bad++; $display("FAIL reset_period: got %0d want 0", period_o); end
    n_cmp++; if (high_o !== 8'd0) begin n_bad++; $display("FAIL reset_high: got %0d want 0", high_o); end
    n_cmp++; if (ovr !== 1'b0) begin n_bad++; $display("FAIL reset_ovr: got %b want 0", ovr); end
    n_cmp++; if (stuck !== 1'b0) begin n_bad++; $display("FAIL reset_stuck: got %b want 0", stuck); end
    n_cmp++; if (dut.state_q !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_steady();
    int vcnt = 0;
    go_idle();
    for (int i = 0; i < 30; i++) begin
      cyc(wave(i, 10, 3));
      if (out_valid) begin
        vcnt++;
        n_cmp++; if (i != 10 && i != 20) begin n_bad++; $display("FAIL steady_pulse_pos: valid at cycle %0d want 10 or 20", i); end
        n_cmp++; if (period_o !== 8'd10) begin n_bad++; $display("FAIL steady_period: got %0d want 10", period_o); end
        n_cmp++; if (high_o !== 8'd3) begin n_bad++; $display("FAIL steady_high: got %0d want 3", high_o); end
      end
    end
    n_cmp++; if (vcnt != 2) begin n_bad++; $display("FAIL steady_count: got %0d want 2", vcnt); end
    $display("test_steady: %0d results", vcnt);
  endtask

  task automatic test_overrun();
    go_idle();
    out_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc((i % 10) < ((i < 10) ? 3 : 5));
      if (i == 10) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_first_valid: got %b want 1", out_valid); end
        n_cmp++; if (high_o !== 8'd3) begin n_bad++; $display("FAIL ovr_first_high: got %0d want 3", high_o); end
      end
      if (i == 19) begin
        n_cmp++; if (ovr !== 1'b0) begin n_bad++; $display("FAIL ovr_early: got %b want 0", ovr); end
      end
      if (i == 20) begin
        n_cmp++; if (ovr !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b want 1", ovr); end
      end
      if (i == 29) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_hold_valid: got %b want 1", out_valid); end
        n_cmp++; if (period_o !== 8'd10) begin n_bad++; $display("FAIL ovr_hold_period: got %0d want 10", period_o); end
        n_cmp++; if (high_o !== 8'd3) begin n_bad++; $display("FAIL ovr_hold_high: got %0d want 3", high_o); end
      end
    end
    out_ready = 1'b1;
    cyc(1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_consume: got %b want 0", out_valid); end
    n_cmp++; if (ovr !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", ovr); end
    clr = 1'b1;
    cyc(1'b0);
    clr = 1'b0;
    n_cmp++; if (ovr !== 1'b0) begin n_bad++; $display("FAIL ovr_clr: got %b want 0", ovr); end
    $display("test_overrun done");
  endtask

  task automatic test_stuck();
    int vcnt = 0;
    go_idle();
    for (int i = 0; i < 256; i++) begin
      cyc(1'b1);
      if (out_valid) vcnt++;
      if (i == 254) begin
        n_cmp++; if (stuck !== 1'b0) begin n_bad++; $display("FAIL stuck_early: got %b want 0 at cycle 254", stuck); end
      end
    end
    n_cmp++; if (stuck !== 1'b1) begin n_bad++; $display("FAIL stuck_set: got %b want 1 at cycle 255", stuck); end
    n_cmp++; if (dut.state_q !== IDLE) begin n_bad++; $display("FAIL stuck_state: got %0d want IDLE", dut.state_q); end
    n_cmp++; if (vcnt != 0) begin n_bad++; $display("FAIL stuck_no_result: got %0d results want 0", vcnt); end
    clr = 1'b1;
    cyc(1'b0);
    clr = 1'b0;
    n_cmp++; if (stuck !== 1'b0) begin n_bad++; $display("FAIL stuck_clr: got %b want 0", stuck); end
    $display("test_stuck done");
  endtask

  task automatic test_duty_change();
    int k = 0;
    logic [W-1:0] exp_h [4];
    exp_h[0] = 8'd3; exp_h[1] = 8'd3; exp_h[2] = 8'd7; exp_h[3] = 8'd7;
    go_idle();
    for (int i = 0; i < 41; i++) begin
      cyc((i % 10) < ((i < 20) ? 3 : 7));
      if (out_valid) begin
        if (k < 4) begin
          n_cmp++; if (period_o !== 8'd10) begin n_bad++; $display("FAIL duty_period[%0d]: got %0d want 10", k, period_o); end
          n_cmp++; if (high_o !== exp_h[k]) begin n_bad++; $display("FAIL duty_high[%0d]: got %0d want %0d", k, high_o, exp_h[k]); end
        end
        k++;
      end
    end
    n_cmp++; if (k != 4) begin n_bad++; $display("FAIL duty_count: got %0d want 4", k); end
    $display("test_duty_change: %0d results", k);
  endtask

  task automatic test_edges();
    int k = 0;
    go_idle();
    for (int i = 0; i < 7; i++) begin
      cyc((i % 2) == 0);
      if (out_valid) begin
        k++;
        n_cmp++; if (period_o !== 8'd2 || high_o !== 8'd1) begin n_bad++; $display("FAIL p2_result: got %0d/%0d want 2/1", period_o, high_o); end
      end
    end
    n_cmp++; if (k != 3) begin n_bad++; $display("FAIL p2_count: got %0d want 3", k); end
    n_cmp++; if (stuck !== 1'b0) begin n_bad++; $display("FAIL p2_stuck: got %b want 0", stuck); end
    go_idle();
    k = 0;
    for (int i = 0; i < 256; i++) begin
      cyc((i % 255) < 254);
      if (out_valid) begin
        k++;
        n_cmp++; if (period_o !== 8'd255 || high_o !== 8'd254) begin n_bad++; $display("FAIL p255_result: got %0d/%0d want 255/254", period_o, high_o); end
      end
    end
    n_cmp++; if (k != 1) begin n_bad++; $display("FAIL p255_count: got %0d want 1", k); end
    n_cmp++; if (stuck !== 1'b0) begin n_bad++; $display("FAIL p255_stuck: got %b want 0", stuck); end
    $display("test_edges done");
  endtask

  task automatic test_reset_mid();
    int k = 0;
    go_idle();
    for (int i = 0; i < 6; i++) cyc(wave(i, 10, 3));
    rst_n = 1'b0;
    #1;
    n_cmp++; if (dut.state_q !== IDLE) begin n_bad++; $display("FAIL rstmid_state: got %0d want IDLE", dut.state_q); end
    cyc(1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 21; i++) begin
      cyc(wave(i, 10, 3));
      if (out_valid) begin
        k++;
        n_cmp++; if (i != 10 && i != 20) begin n_bad++; $display("FAIL rstmid_pos: valid at cycle %0d want 10 or 20", i); end
        n_cmp++; if (period_o !== 8'd10 || high_o !== 8'd3) begin n_bad++; $display("FAIL rstmid_result: got %0d/%0d want 10/3", period_o, high_o); end
      end
    end
    n_cmp++; if (k != 2) begin n_bad++; $display("FAIL rstmid_count: got %0d want 2", k); end
    go_idle();
    k = 0;
    for (int i = 0; i < 21; i++) begin
      en = (i != 6);
      cyc(wave(i, 10, 3));
      if (out_valid) begin
        k++;
        n_cmp++; if (i != 20) begin n_bad++; $display("FAIL endrop_pos: valid at cycle %0d want 20", i); end
        n_cmp++; if (period_o !== 8'd10 || high_o !== 8'd3) begin n_bad++; $display("FAIL endrop_result: got %0d/%0d want 10/3", period_o, high_o); end
      end
    end
    en = 1'b1;
    n_cmp++; if (k != 1) begin n_bad++; $display("FAIL endrop_count: got %0d want 1", k); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_steady();
    test_overrun();
    test_stuck();
    test_duty_change();
    test_edges();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
